joybus_host_rx: RTL

- Host-side Joybus receiver. Decodes the controller's response frame on the bidirectional data line after the host transmitter has finished sending its command.
- Oversamples the line at 25 clocks/us and classifies each bit by its low-pulse width. The trailing stop bit is identified by the line idling high afterwards.
- Emits bytes MSB-first with a one-cycle valid strobe, then signals frame completion or error to the controller-polling logic.

---
 rtl/joybus_host_rx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/joybus_host_rx.sv
// Host-side Joybus response receiver: synchronises the line, classifies each bit by
// its low-pulse width and assembles MSB-first bytes until the line idles high.
module joybus_host_rx #(
  parameter int SAMPLE_THRESH = 50,
  parameter int GLITCH_MAX    = 5,
  parameter int LOW_MAX       = 125,
  parameter int IDLE_TIMEOUT  = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       JB_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_done,
  output logic       rx_err,
  output logic [5:0] rx_byte_cnt
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, ERR_WAIT} state_t;

  localparam logic [6:0] THRESH_C = 7'(SAMPLE_THRESH);
  localparam logic [6:0] GLITCH_C = 7'(GLITCH_MAX);
  // Limits fire on the cycle whose edge would bring the counter to the limit.
  localparam logic [6:0] LOW_LIM  = 7'(LOW_MAX - 1);
  localparam logic [6:0] IDLE_LIM = 7'(IDLE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        pending_q, pending_d;
  logic        pend_bit_q, pend_bit_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_done_q, rx_done_d;
  logic        rx_err_q, rx_err_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;

  logic fall_s;
  logic started_s;
  logic commit_s;

  always_comb begin
    sync1_d    = JB_RX;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q + 7'd1;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    pending_d  = pending_q;
    pend_bit_d = pend_bit_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_done_d  = 1'b0;
    rx_err_d   = 1'b0;
    byte_cnt_d = byte_cnt_q;
    commit_s   = 1'b0;

    fall_s    = prev_q & ~sync2_q;
    started_s = pending_q | (bit_cnt_q != 4'd0) | (byte_cnt_q != 6'd0);

    if (!rx_en) begin
      state_d   = IDLE;
      cnt_d     = 7'd0;
      pending_d = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = 7'd0;
          if (fall_s) begin
            state_d    = LOW;
            byte_cnt_d = 6'd0;
            bit_cnt_d  = 4'd0;
            pending_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        LOW: begin
          if (sync2_q) begin
            cnt_d = 7'd0;
            if (cnt_q < GLITCH_C) begin
              state_d = started_s ? HIGH : IDLE;
            end else begin
              pend_bit_d = (cnt_q >= THRESH_C) ? 1'b0 : 1'b1;
              pending_d  = 1'b1;
              state_d    = HIGH;
            end
          end else if (cnt_q == LOW_LIM) begin
            cnt_d    = 7'd0;
            rx_err_d = 1'b1;
            state_d  = ERR_WAIT;
          end else begin
            state_d = LOW;
          end
        end
        HIGH: begin
          if (fall_s) begin
            cnt_d    = 7'd0;
            state_d  = LOW;
            commit_s = pending_q;
          end else if (cnt_q == IDLE_LIM) begin
            // Whatever is still pending here is the stop bit.
            cnt_d     = 7'd0;
            pending_d = 1'b0;
            state_d   = IDLE;
            if ((bit_cnt_q == 4'd0) && (byte_cnt_q != 6'd0)) begin
              rx_done_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
          end else begin
            state_d = HIGH;
          end
        end
        ERR_WAIT: begin
          cnt_d   = 7'd0;
          state_d = sync2_q ? IDLE : ERR_WAIT;
        end
        default: begin
          cnt_d   = 7'd0;
          state_d = IDLE;
        end
      endcase

      if (commit_s) begin
        shift_d   = {shift_q[6:0], pend_bit_q};
        pending_d = 1'b0;
        if (bit_cnt_q == 4'd7) begin
          rx_data_d  = {shift_q[6:0], pend_bit_q};
          rx_valid_d = 1'b1;
          bit_cnt_d  = 4'd0;
          byte_cnt_d = (byte_cnt_q == 6'd63) ? 6'd63 : byte_cnt_q + 6'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 7'd0;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 4'd0;
      pending_q  <= 1'b0;
      pend_bit_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      byte_cnt_q <= 6'd0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      pending_q  <= pending_d;
      pend_bit_q <= pend_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = (state_q != IDLE);
  assign rx_done     = rx_done_q;
  assign rx_err      = rx_err_q;
  assign rx_byte_cnt = byte_cnt_q;

endmodule
